// File: rtl/rv32i_types.sv
// rtl/rv32i_types.sv - shared RV32I pipeline types used by fetch, queue and decode
package rv32i_types;

    typedef struct packed {
        logic [31:0] instruction;
        logic [31:0] pc;
        logic [63:0] order;
    } iq_entry_t;

endpackage

// File: rtl/iq_popcount.sv
// rtl/iq_popcount.sv - population count of the per-lane enqueue strobes
module iq_popcount #(
    parameter  int N  = 1,
    localparam int CW = $clog2(N + 1)
) (
    input  logic [N-1:0]  i_bits,
    output logic [CW-1:0] o_count
);

    always_comb begin
        o_count = '0;
        for (int i = 0; i < N; i++) begin
            o_count = o_count + CW'(i_bits[i]);
        end
    end

endmodule

// File: rtl/instr_queue.sv
// rtl/instr_queue.sv - circular fetch-to-decode instruction queue with NSIZE-lane enqueue
module instr_queue
    import rv32i_types::*;
#(
    parameter int DEPTH_BITS = 8,
    parameter int NSIZE      = 1
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    flush,
    input  logic [NSIZE-1:0]        enqueue,
    input  iq_entry_t [NSIZE-1:0]   instructions,
    output logic [DEPTH_BITS:0]     freespace,
    output logic                    head_valid,
    output iq_entry_t               head,
    input  logic                    dequeue
);

    localparam int DEPTH = 1 << DEPTH_BITS;
    localparam int PW    = DEPTH_BITS + 1;
    localparam int CW    = $clog2(NSIZE + 1);

    iq_entry_t             r_mem [DEPTH];
    logic [DEPTH_BITS-1:0] r_head_ptr;
    logic [DEPTH_BITS-1:0] r_tail_ptr;
    logic [PW-1:0]         r_count;

    logic [CW-1:0]         w_n_enq;
    logic [PW-1:0]         w_n_enq_ext;
    logic [PW-1:0]         w_n_acc;
    logic                  w_deq_fire;

    iq_popcount #(.N(NSIZE)) u_popcount (
        .i_bits  (enqueue),
        .o_count (w_n_enq)
    );

    assign w_n_enq_ext = PW'(w_n_enq);
    // Lanes beyond the available room are silently dropped.
    assign w_n_acc     = (w_n_enq_ext > freespace) ? freespace : w_n_enq_ext;
    assign w_deq_fire  = dequeue && head_valid;

    assign freespace  = PW'(DEPTH) - r_count;
    assign head_valid = (r_count != '0);
    assign head       = r_mem[r_head_ptr];

    always_ff @(posedge clk) begin
        if (rst) begin
            r_head_ptr <= '0;
            r_tail_ptr <= '0;
            r_count    <= '0;
        end else if (flush) begin
            r_head_ptr <= '0;
            r_tail_ptr <= '0;
            r_count    <= '0;
        end else begin
            r_tail_ptr <= r_tail_ptr + w_n_acc[DEPTH_BITS-1:0];
            r_head_ptr <= r_head_ptr + DEPTH_BITS'(w_deq_fire);
            r_count    <= r_count + w_n_acc - PW'(w_deq_fire);
        end
    end

    // Storage is not reset; pointer arithmetic wraps a burst across DEPTH-1 -> 0.
    always_ff @(posedge clk) begin
        if (!rst && !flush) begin
            for (int i = 0; i < NSIZE; i++) begin
                if (PW'(i) < w_n_acc) begin
                    r_mem[r_tail_ptr + DEPTH_BITS'(i)] <= instructions[i];
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            assert (((enqueue + NSIZE'(1)) & enqueue) == '0)
                else $error("instr_queue: non-contiguous enqueue mask %b", enqueue);
        end
    end

endmodule

// File: tb/tb_instr_queue.sv
// tb/tb_instr_queue.sv - scoreboard bench for instr_queue at DEPTH_BITS=3, NSIZE=4
module tb_instr_queue;
    import rv32i_types::*;

    localparam int DB    = 3;
    localparam int NS    = 4;
    localparam int DEPTH = 1 << DB;

    logic                  clk = 1'b0;
    logic                  rst;
    logic                  flush;
    logic [NS-1:0]         enqueue;
    iq_entry_t [NS-1:0]    instructions;
    logic [DB:0]           freespace;
    logic                  head_valid;
    iq_entry_t             head;
    logic                  dequeue;

    iq_entry_t exp_q [$];
    int        seq     = 0;
    int        n_err   = 0;
    int        n_chk   = 0;

    always #5 clk = ~clk;

    instr_queue #(.DEPTH_BITS(DB), .NSIZE(NS)) dut (
        .clk          (clk),
        .rst          (rst),
        .flush        (flush),
        .enqueue      (enqueue),
        .instructions (instructions),
        .freespace    (freespace),
        .head_valid   (head_valid),
        .head         (head),
        .dequeue      (dequeue)
    );

    task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    function automatic iq_entry_t make_entry(input int k);
        iq_entry_t e;
        e.pc          = 32'h6000_0000 + 32'(k * 4);
        e.instruction = 32'(k) * 32'h0101_0137 ^ 32'h0000_0013;
        e.order       = 64'(k);
        return e;
    endfunction

    task automatic check_state();
        check("freespace", 128'(freespace), 128'(DEPTH - exp_q.size()));
        check("head_valid", 128'(head_valid), 128'(exp_q.size() != 0));
        if (exp_q.size() != 0) check("head", 128'(head), 128'(exp_q[0]));
    endtask

    // One cycle: check the state left by the previous edge, then drive and update the model.
    task automatic step(input logic [NS-1:0] mask, input logic deq, input logic fl);
        int n, room, acc;
        @(negedge clk);
        check_state();
        enqueue = mask;
        dequeue = deq;
        flush   = fl;
        n = 0;
        for (int i = 0; i < NS; i++) begin
            instructions[i] = make_entry(seq + i);
            if (mask[i]) n++;
        end
        room = DEPTH - exp_q.size();
        acc  = (n > room) ? room : n;
        if (fl) begin
            exp_q.delete();
        end else begin
            if (deq && exp_q.size() != 0) void'(exp_q.pop_front());
            for (int i = 0; i < acc; i++) exp_q.push_back(make_entry(seq + i));
        end
        seq += NS;
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1; enqueue = '0; dequeue = 1'b0; flush = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        exp_q.delete();
    endtask

    initial begin
        rst = 1'b1; flush = 1'b0; enqueue = '0; dequeue = 1'b0;
        for (int i = 0; i < NS; i++) instructions[i] = '0;
        do_reset();

        for (int i = 0; i < 10; i++) step(4'b0000, 1'b0, 1'b0);

        // Four-lane burst then drain in pc order.
        step(4'b1111, 1'b0, 1'b0);
        for (int i = 0; i < 4; i++) step(4'b0000, 1'b1, 1'b0);
        step(4'b0000, 1'b0, 1'b0);

        // Fill, overflow drop, single dequeue, refill, full enq+deq.
        step(4'b1111, 1'b0, 1'b0);
        step(4'b1111, 1'b0, 1'b0);
        step(4'b0011, 1'b0, 1'b0);
        step(4'b0000, 1'b1, 1'b0);
        step(4'b0001, 1'b0, 1'b0);
        step(4'b0001, 1'b1, 1'b0);
        for (int i = 0; i < 7; i++) step(4'b0000, 1'b1, 1'b0);
        step(4'b0000, 1'b1, 1'b0);

        // Move tail to 6, then a burst straddling 7 -> 0.
        step(4'b0001, 1'b0, 1'b0);
        step(4'b0000, 1'b1, 1'b0);
        step(4'b1111, 1'b0, 1'b0);
        for (int i = 0; i < 4; i++) step(4'b0000, 1'b1, 1'b0);

        // Flush with 5 queued plus a concurrent enqueue and dequeue.
        step(4'b1111, 1'b0, 1'b0);
        step(4'b0001, 1'b0, 1'b0);
        step(4'b1111, 1'b1, 1'b1);
        step(4'b0011, 1'b0, 1'b0);
        step(4'b0000, 1'b1, 1'b0);
        step(4'b0000, 1'b1, 1'b0);

        // Reset in the middle of traffic.
        step(4'b0111, 1'b0, 1'b0);
        do_reset();
        step(4'b0000, 1'b1, 1'b0);

        for (int i = 0; i < 300; i++) begin
            int n;
            n = $urandom_range(0, NS);
            step(NS'((1 << n) - 1), 1'($urandom_range(0, 1)), ($urandom_range(0, 39) == 0));
        end
        for (int i = 0; i < DEPTH + 1; i++) step(4'b0000, 1'b1, 1'b0);
        @(negedge clk);
        check_state();

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
